// File: rtl/neuron_mac.sv
// neuron_mac: per-neuron multiply-accumulate for the activation stage.
// A neuron takes a bias on start and then N_IN (activation, weight) beats.
// It emits one saturated, optionally down-shifted signed sum as a
// single-cycle valid_out pulse. Activations are unsigned and weights are
// signed two's complement.
module neuron_mac #(
   parameter int WIDTH_IN  = 8,
   parameter int WIDTH_W   = 8,
   parameter int WIDTH_OUT = 16,
   parameter int N_IN      = 16,
   parameter int ACC_W     = 24,
   parameter int SHIFT     = 0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic signed [WIDTH_OUT-1:0] bias,
   input  logic                        clear,
   input  logic                        valid_in,
   output logic                        in_ready,
   input  logic        [WIDTH_IN-1:0]  act_in,
   input  logic signed [WIDTH_W-1:0]   weight_in,
   output logic                        busy,
   output logic                        valid_out,
   output logic signed [WIDTH_OUT-1:0] data_out
);

   // The counter keeps at least one bit, so that N_IN == 1 still elaborates.
   localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_IN - 1);

   // Saturation bounds, expressed at accumulator width.
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      signed'({{(ACC_W-WIDTH_OUT+1){1'b0}}, {(WIDTH_OUT-1){1'b1}}});
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                        r_state;
   state_t                        w_next_state;
   logic signed [ACC_W-1:0]       r_acc;
   logic        [CNT_W-1:0]       r_cnt;
   logic                          r_valid_out;
   logic signed [WIDTH_OUT-1:0]   r_data_out;

   logic                          w_accept;
   logic                          w_last_beat;
   logic                          w_emit;
   logic signed [ACC_W-1:0]       w_act_ext;
   logic signed [ACC_W-1:0]       w_wgt_ext;
   logic signed [ACC_W-1:0]       w_prod;
   logic signed [ACC_W-1:0]       w_shifted;
   logic signed [WIDTH_OUT-1:0]   w_sat;

   assign in_ready    = (r_state == S_ACCUM);
   assign busy        = (r_state != S_IDLE);
   assign valid_out   = r_valid_out;
   assign data_out    = r_data_out;

   assign w_accept    = in_ready && valid_in;
   assign w_last_beat = (r_cnt == LAST_BEAT);
   // A result leaves only from DONE, and only when clear does not abort it.
   assign w_emit      = (r_state == S_DONE) && !clear;

   // The activation is zero-extended so it stays non-negative. The weight is
   // sign-extended. The product is formed directly at accumulator width.
   assign w_act_ext   = signed'(ACC_W'(act_in));
   assign w_wgt_ext   = ACC_W'(weight_in);
   assign w_prod      = w_act_ext * w_wgt_ext;

   // The arithmetic shift floors toward -inf.
   assign w_shifted   = r_acc >>> SHIFT;

   // Clamp the shifted accumulator to the signed output range.
   always_comb begin
      w_sat = w_shifted[WIDTH_OUT-1:0];
      if (w_shifted > SAT_MAX) begin
         w_sat = {1'b0, {(WIDTH_OUT-1){1'b1}}};
      end else if (w_shifted < SAT_MIN) begin
         w_sat = {1'b1, {(WIDTH_OUT-1){1'b0}}};
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: registers take non-blocking assignments. Every flop then samples
      // pre-edge values, whatever order the always blocks are evaluated in.
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic. clear overrides every other input.
   always_comb begin
      // NOTE: the default comes first, so every path assigns w_next_state
      // and no latch is inferred.
      w_next_state = r_state;
      if (clear) begin
         w_next_state = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (start) w_next_state = S_ACCUM;
            S_ACCUM: if (w_accept && w_last_beat) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
         endcase
      end
   end

   // Accumulator and beat counter: load the bias on start, then add one
   // product per accepted beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (clear) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if ((r_state == S_IDLE) && start) begin
         r_acc <= ACC_W'(bias);
         r_cnt <= '0;
      end else if (w_accept) begin
         r_acc <= r_acc + w_prod;
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Result register and strobe. data_out holds its value between results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid_out <= 1'b0;
         r_data_out  <= '0;
      end else begin
         r_valid_out <= w_emit;
         if (w_emit) begin
            r_data_out <= w_sat;
         end
      end
   end

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: table-driven scoreboard bench for neuron_mac.
// Two instances share the same stimulus. One has SHIFT=0 and the other has
// SHIFT=2, and both use N_IN=4. Each neuron in the table carries the
// expected result for both instances. Expected results are queued when a
// neuron is driven, and a monitor pops and compares them on every valid_out.
module tb_neuron_mac;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic signed [15:0] bias = '0;
   logic               clear = 1'b0;
   logic               valid_in = 1'b0;
   logic        [7:0]  act_in = '0;
   logic signed [7:0]  weight_in = '0;

   logic               rdy0, busy0, valid0;
   logic signed [15:0] data0;
   logic               rdy2, busy2, valid2;
   logic signed [15:0] data2;

   int n_checks = 0;
   int n_errors = 0;
   int n_pulses = 0;
   int n_exp_pulses = 0;
   int last_exp0 = 0;
   int last_exp2 = 0;
   int q0[$];
   int q2[$];
   logic prev_v0 = 1'b0;

   typedef struct {
      int bias;
      int act[4];
      int w[4];
      int exp0;   // expected result with SHIFT=0
      int exp2;   // expected result with SHIFT=2
   } vec_t;

   vec_t tbl[10];

   always #5 clk = ~clk;

   neuron_mac #(.WIDTH_IN(8), .WIDTH_W(8), .WIDTH_OUT(16), .N_IN(4),
                .ACC_W(24), .SHIFT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .bias(bias), .clear(clear),
      .valid_in(valid_in), .in_ready(rdy0), .act_in(act_in),
      .weight_in(weight_in), .busy(busy0), .valid_out(valid0), .data_out(data0)
   );

   neuron_mac #(.WIDTH_IN(8), .WIDTH_W(8), .WIDTH_OUT(16), .N_IN(4),
                .ACC_W(24), .SHIFT(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .bias(bias), .clear(clear),
      .valid_in(valid_in), .in_ready(rdy2), .act_in(act_in),
      .weight_in(weight_in), .busy(busy2), .valid_out(valid2), .data_out(data2)
   );

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Scoreboard monitor: every strobe must match the oldest queued result,
   // and every strobe must last exactly one cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_v0 = 1'b0;
      end else begin
         if (valid0) begin
            n_pulses++;
            if (prev_v0) check("pulse_width", 2, 1);
            if (q0.size() == 0) check("unexpected_valid_s0", 1, 0);
            else check("data_out_s0", int'(data0), q0.pop_front());
         end
         if (valid2) begin
            if (q2.size() == 0) check("unexpected_valid_s2", 1, 0);
            else check("data_out_s2", int'(data2), q2.pop_front());
         end
         check("valid_align", int'(valid2), int'(valid0));
         prev_v0 = valid0;
      end
   end

   // Drive one neuron. The caller must be positioned at a negedge; the task
   // returns at the negedge of the result cycle, so back-to-back calls issue
   // the next start in the valid_out cycle. gaps inserts bubbles that carry
   // a spurious start. clr_done asserts clear in the DONE cycle. Otherwise
   // the DONE cycle carries a start that must be ignored.
   task automatic run_neuron(input vec_t v, input bit gaps, input bit clr_done);
      if (!clr_done) begin
         q0.push_back(v.exp0);
         q2.push_back(v.exp2);
         n_exp_pulses++;
         last_exp0 = v.exp0;
         last_exp2 = v.exp2;
      end
      start = 1'b1;
      bias  = 16'(v.bias);
      @(negedge clk);
      start = 1'b0;
      check("accum_busy", int'(busy0), 1);
      check("accum_in_ready", int'(rdy0), 1);
      for (int i = 0; i < 4; i++) begin
         if (gaps) begin
            valid_in  = 1'b0;
            act_in    = 8'($urandom);
            weight_in = 8'($urandom);
            start     = 1'b1;
            bias      = 16'sd1234;
            @(negedge clk);
            start     = 1'b0;
            @(negedge clk);
         end
         valid_in  = 1'b1;
         act_in    = 8'(v.act[i]);
         weight_in = 8'(v.w[i]);
         @(negedge clk);
      end
      valid_in = 1'b0;
      // DONE cycle: no strobe yet, and no beats accepted.
      check("done_busy", int'(busy0), 1);
      check("done_in_ready", int'(rdy0), 0);
      check("done_no_valid", int'(valid0), 0);
      if (clr_done) begin
         clear = 1'b1;
      end else begin
         start = 1'b1;
         bias  = 16'sd777;
      end
      @(negedge clk);
      clear = 1'b0;
      start = 1'b0;
      check("result_valid", int'(valid0), clr_done ? 0 : 1);
      check("result_idle", int'(busy0), 0);
   endtask

   initial begin
      // Expected results, hand-derived: sum = bias + sum(act*w).
      // exp0 = sat16(sum); exp2 = sat16(floor(sum / 4)).
      tbl[0] = '{bias: 10,     act: '{1, 2, 3, 4},         w: '{1, 1, 1, 1},         exp0: 20,     exp2: 5};
      tbl[1] = '{bias: 32000,  act: '{127, 127, 127, 127}, w: '{127, 127, 127, 127}, exp0: 32767,  exp2: 24129};
      tbl[2] = '{bias: -32768, act: '{255, 255, 255, 255}, w: '{-128, -128, -128, -128}, exp0: -32768, exp2: -32768};
      tbl[3] = '{bias: -5,     act: '{9, 200, 3, 255},     w: '{0, 0, 0, 0},         exp0: -5,     exp2: -2};
      tbl[4] = '{bias: 9,      act: '{9, 200, 3, 255},     w: '{0, 0, 0, 0},         exp0: 9,      exp2: 2};
      tbl[5] = '{bias: 0,      act: '{200, 17, 255, 1},    w: '{-3, 5, -128, 127},   exp0: -32768, exp2: -8257};
      tbl[6] = '{bias: 32767,  act: '{1, 0, 0, 0},         w: '{1, 0, 0, 0},         exp0: 32767,  exp2: 8192};
      tbl[7] = '{bias: -32768, act: '{1, 0, 0, 0},         w: '{-1, 0, 0, 0},        exp0: -32768, exp2: -8193};
      tbl[8] = '{bias: -7,     act: '{0, 0, 0, 0},         w: '{7, 7, 7, 7},         exp0: -7,     exp2: -2};
      tbl[9] = '{bias: 32767,  act: '{0, 0, 0, 0},         w: '{0, 0, 0, 0},         exp0: 32767,  exp2: 8191};

      // Reset state.
      #1;
      check("reset_busy", int'(busy0), 0);
      check("reset_in_ready", int'(rdy0), 0);
      check("reset_valid", int'(valid0), 0);
      check("reset_data", int'(data0), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Table: back-to-back neurons. The first pass has no gaps; the second
      // pass has bubbles and spurious starts during ACCUM.
      for (int i = 0; i < 10; i++) run_neuron(tbl[i], 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)  run_neuron(tbl[i], 1'b1, 1'b0);

      // Clear after two beats. clear wins over start and valid_in arriving in
      // the same cycle, and data_out must hold the previous result.
      @(negedge clk);
      start = 1'b1;
      bias  = 16'sd10;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         valid_in  = 1'b1;
         act_in    = 8'd50;
         weight_in = 8'sd60;
         @(negedge clk);
      end
      clear     = 1'b1;
      start     = 1'b1;
      valid_in  = 1'b1;
      @(negedge clk);
      clear    = 1'b0;
      start    = 1'b0;
      valid_in = 1'b0;
      check("clear_busy", int'(busy0), 0);
      check("clear_in_ready", int'(rdy0), 0);
      check("clear_hold_s0", int'(data0), last_exp0);
      check("clear_hold_s2", int'(data2), last_exp2);
      repeat (8) @(negedge clk);
      run_neuron(tbl[0], 1'b0, 1'b0);

      // Clear in the DONE cycle suppresses the result.
      run_neuron(tbl[1], 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      check("clear_done_hold", int'(data0), last_exp0);
      run_neuron(tbl[0], 1'b0, 1'b0);

      // Asynchronous reset in mid-ACCUM: the outputs clear immediately.
      @(negedge clk);
      start = 1'b1;
      bias  = 16'sd50;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         valid_in  = 1'b1;
         act_in    = 8'd3;
         weight_in = 8'sd4;
         @(negedge clk);
      end
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", int'(busy0), 0);
      check("arst_in_ready", int'(rdy0), 0);
      check("arst_valid", int'(valid0), 0);
      check("arst_data_s0", int'(data0), 0);
      check("arst_data_s2", int'(data2), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      valid_in = 1'b0;
      @(negedge clk);
      run_neuron(tbl[3], 1'b0, 1'b0);

      repeat (4) @(negedge clk);
      check("queue_empty_s0", q0.size(), 0);
      check("queue_empty_s2", q2.size(), 0);
      check("pulse_count", n_pulses, n_exp_pulses);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
